display_scan_mux: RTL
=====================

Name: display_scan_mux

Overview:
- Time-multiplexed scan driver for the multi-digit 7-segment display of the security system.
- Holds one 4-bit code per digit and presents one code at a time on MSB/B/C/LSB to the downstream 7-segment decoder.
- Drives the matching active-low digit-enable line for each code.
- New display contents are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clock cycles per digit slot (blank + show); must satisfy PRESCALE > BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (anti-ghosting); must be >= 1.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe; captures digits_in and blank_mask into the shadow buffer.
- digits_in  in  4*N_DIGITS  digit codes; digit k occupies bits [4k+3:4k], digit 0 is the first digit scanned.
- blank_mask  in  N_DIGITS  bit k = 1 keeps digit k dark for the whole frame.
- MSB  out  1  bit 3 of the current digit code.
- B  out  1  bit 2 of the current digit code.
- C  out  1  bit 1 of the current digit code.
- LSB  out  1  bit 0 of the current digit code.
- digit_en_n  out  N_DIGITS  active-low digit enables; at most one bit is low at any time.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.
- pending  out  1  high while shadow data waits for the next frame commit.

Behaviour:
- Reset (async assert, any time):
  - slot counter = 0, digit index = 0, state = BLANK.
  - active and shadow digit registers = 0; active and shadow masks = all 1 (dark).
  - MSB/B/C/LSB = 0, digit_en_n = all 1, frame_done = 0, pending = 0.
  - Deassertion is sampled synchronously; the first BLANK slot starts on the first edge after release.
- Slot counter: counts 0..PRESCALE-1, then wraps to 0; the wrap marks the slot end.
- FSM, two states:
  - BLANK: counter 0..BLANK_CYCLES-1. digit_en_n = all 1. The code outputs hold the current index's active code, updated on the edge entering BLANK, so the code is stable BLANK_CYCLES before the enable asserts.
  - SHOW: counter BLANK_CYCLES..PRESCALE-1. digit_en_n[index] = 0 unless the active mask bit for that index is 1, in which case all enables stay 1.
  - SHOW -> BLANK at slot end; index advances by 1, and index N_DIGITS-1 wraps to 0.
- Frame boundary (slot end while index = N_DIGITS-1):
  - frame_done = 1 for exactly that one cycle.
  - If pending = 1, the shadow codes and mask are copied to active and pending clears in the same edge.
  - The new data is visible starting with digit 0 of the next frame.
- Load:
  - On load = 1, the shadow registers capture the inputs and pending is set.
  - Repeated loads before a commit overwrite the shadow buffer; the last one wins.
  - If load coincides with a frame boundary, digits_in and blank_mask are committed directly to active, and pending ends at 0.
- Timing:
  - Frame length = N_DIGITS*PRESCALE cycles.
  - Enable-low time per slot = PRESCALE-BLANK_CYCLES cycles.
  - Latency from load to display ranges from 1 cycle (load on a boundary) up to one full frame.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset/idle (N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2): assert rst mid-SHOW -> immediately digit_en_n=4'b1111, code=0000, pending=0. After release, digit_en_n stays 1111 because the reset mask is dark; frame_done pulses every 32 cycles.
- Basic scan: load digits_in=16'h4321, blank_mask=0000 -> pending=1 until the first frame_done, then cleared.
  - Next frame: code 1 with digit_en_n=1110, then 2/1101, 3/1011, 4/0111.
  - Each enable is low for 6 cycles, preceded by 2 all-high cycles with the code already stable.
- Blank mask: load 16'h9999 with blank_mask=0101 -> digits 0 and 2 never enable; digits 1 and 3 enable normally; the code output still shows 9 during the masked slots.
- Double-buffer: load 16'h1111 mid-frame, then 16'h2222 before the boundary -> the current frame is unchanged, and the next frame shows all 2s with no 1s.
- Boundary collision: load 16'hAAAA on the exact frame_done cycle -> pending stays 0, and the next frame shows A on all digits.
- Wrap/timing: run 3 frames -> frame_done spacing is exactly 32 cycles, and no cycle has more than one digit_en_n bit low.

Source files
------------

// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexed scan driver for an N_DIGITS 7-segment display. Each
//   digit gets a slot of PRESCALE cycles. The first BLANK_CYCLES cycles of a
//   slot keep every digit dark (anti-ghosting), and the rest of the slot
//   enables that digit. New contents go into a shadow buffer. They are
//   committed to the active buffer only at a frame boundary, so one frame
//   never mixes old and new digits.
// Ports:
//   clk, rst            clock, async active-high reset
//   load                strobe that captures digits_in/blank_mask into the shadow
//   digits_in           4 bits per digit, digit 0 in bits [3:0]
//   blank_mask          bit k = 1 keeps digit k dark for the whole frame
//   MSB, B, C, LSB      current digit code, bit 3 .. bit 0
//   digit_en_n          active-low digit enables, at most one bit low
//   frame_done          one-cycle pulse in the last cycle of the last slot
//   pending             shadow data waiting for a frame commit

// Per-digit double buffer: a shadow copy plus an active copy.
// nxt_* is the active value after the current edge. It is used so that the
// first slot of a new frame already shows the committed data.
module display_digit_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       boundary,
  input  logic       pending,
  input  logic [3:0] code_in,
  input  logic       mask_in,
  output logic [3:0] act_code,
  output logic       act_mask,
  output logic [3:0] nxt_code,
  output logic       nxt_mask
);
  logic [3:0] sh_code;
  logic       sh_mask;

  always_comb begin
    nxt_code = act_code;
    nxt_mask = act_mask;
    if (boundary) begin
      // A load that lands on the boundary bypasses the shadow buffer.
      if (load) begin
        nxt_code = code_in;
        nxt_mask = mask_in;
      end else if (pending) begin
        nxt_code = sh_code;
        nxt_mask = sh_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_code  <= 4'h0;
      sh_mask  <= 1'b1;
      act_code <= 4'h0;
      act_mask <= 1'b1;
    end else begin
      if (load) begin
        sh_code <= code_in;
        sh_mask <= mask_in;
      end
      act_code <= nxt_code;
      act_mask <= nxt_mask;
    end
  end
endmodule

module display_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic                  MSB,
  output logic                  B,
  output logic                  C,
  output logic                  LSB,
  output logic [N_DIGITS-1:0]   digit_en_n,
  output logic                  frame_done,
  output logic                  pending
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [IW-1:0]              idx, idx_nxt;
  logic                       slot_end, boundary, fd_nxt;
  logic [3:0]                 code_q;
  logic [N_DIGITS-1:0]        en_nxt;
  logic [N_DIGITS-1:0][3:0]   act_code, nxt_code;
  logic [N_DIGITS-1:0]        act_mask, nxt_mask;

  // Per-digit buffers.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    display_digit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .boundary (boundary),
      .pending  (pending),
      .code_in  (digits_in[4*k +: 4]),
      .mask_in  (blank_mask[k]),
      .act_code (act_code[k]),
      .act_mask (act_mask[k]),
      .nxt_code (nxt_code[k]),
      .nxt_mask (nxt_mask[k])
    );
  end

  // Slot and index sequencing. The registered outputs are computed from the
  // next-cycle values, so each output lines up with the cnt/state it belongs to.
  always_comb begin
    slot_end  = (cnt == LAST_CNT);
    boundary  = slot_end && (idx == LAST_IDX);
    cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
    idx_nxt   = idx;
    if (slot_end) idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);

    state_nxt = state;
    case (state)
      BLANK: if (cnt_nxt == BLANK_END) state_nxt = SHOW;
      SHOW:  if (slot_end)             state_nxt = BLANK;
      default:                         state_nxt = BLANK;
    endcase

    en_nxt = '1;
    if (state_nxt == SHOW && !nxt_mask[idx_nxt]) en_nxt[idx_nxt] = 1'b0;
    fd_nxt = (cnt_nxt == LAST_CNT) && (idx_nxt == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      code_q     <= 4'h0;
      digit_en_n <= '1;
      frame_done <= 1'b0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      digit_en_n <= en_nxt;
      frame_done <= fd_nxt;
      // The code changes only on entry to BLANK, so it is stable for the
      // whole blank time before its enable goes low.
      if (slot_end) code_q <= nxt_code[idx_nxt];
      if (boundary)  pending <= 1'b0;
      else if (load) pending <= 1'b1;
    end
  end

  assign MSB = code_q[3];
  assign B   = code_q[2];
  assign C   = code_q[1];
  assign LSB = code_q[0];
endmodule
